alu_operand_stage: RTL and testbench

Parametrised successor to the ALU source-B select: chooses both ALU operands (A and B) for the execute stage and registers them in a single pipeline slot with a valid/ready handshake. Operand B has four source modes, replacing the old register-or-sign-immediate choice. Both operands optionally take bypassed results from the EX/MEM and MEM/WB stages. The block sits between the decode stage (register file read ports, immediate field) and the ALU of the pipelined core.

---
 rtl/alu_pkg.sv | 15 +
 rtl/operand_fwd.sv | 38 +++
 rtl/alu_operand_stage.sv | 100 ++++++++++
 tb/tb_alu_operand_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand-B source encodings and default datapath sizes.
package alu_pkg;

    localparam int ALU_WIDTH  = 32;
    localparam int ALU_IMM_W  = 16;
    localparam int ALU_ADDR_W = 5;

    typedef enum logic [1:0] {
        ALU_SRC_REG   = 2'd0,
        ALU_SRC_SEXT  = 2'd1,
        ALU_SRC_ZEXT  = 2'd2,
        ALU_SRC_UPPER = 2'd3
    } alu_src_e;

endpackage

// File: rtl/operand_fwd.sv
// Per-operand bypass: picks EX/MEM, then MEM/WB, then register-file data.
// Compare logic is present only when ALU_OPERAND_FWD_EN is defined.
module operand_fwd #(
    parameter int WIDTH  = alu_pkg::ALU_WIDTH,
    parameter int ADDR_W = alu_pkg::ALU_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  d,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [WIDTH-1:0]  ex_data,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    output logic [WIDTH-1:0]  q
);

`ifdef ALU_OPERAND_FWD_EN
    logic addr_nz;
    assign addr_nz = (addr != '0);

    // Priority mux: the younger EX/MEM result wins over MEM/WB; r0 is never bypassed.
    always_comb begin
        // NOTE: q gets a value on every path first, so no latch is inferred.
        q = d;
        if (ex_we && (ex_addr == addr) && addr_nz)
            q = ex_data;
        else if (wb_we && (wb_addr == addr) && addr_nz)
            q = wb_data;
    end
`else
    // Bypass disabled: the hazard unit stalls on RAW hazards, so read data is always current.
    logic unused_bypass;
    assign unused_bypass = ^{addr, ex_we, ex_addr, ex_data, wb_we, wb_addr, wb_data};
    assign q = d;
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: forwards both register operands, selects operand B by mode,
// and holds the result in one valid/ready pipeline slot.
// Optional bypass logic is enabled with the ALU_OPERAND_FWD_EN macro.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int IMM_W  = ALU_IMM_W,
    parameter int ADDR_W = ALU_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  rd1,
    input  logic [WIDTH-1:0]  rd2,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        alu_src,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [WIDTH-1:0]  ex_data,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  src_a,
    output logic [WIDTH-1:0]  src_b,
    output logic [WIDTH-1:0]  store_data
);

    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] b_val;
    logic             accept;

    operand_fwd #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_fwd_a (
        .addr    (rs_addr),
        .d       (rd1),
        .ex_we   (ex_we),
        .ex_addr (ex_addr),
        .ex_data (ex_data),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .q       (a_val)
    );

    operand_fwd #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_fwd_b (
        .addr    (rt_addr),
        .d       (rd2),
        .ex_we   (ex_we),
        .ex_addr (ex_addr),
        .ex_data (ex_data),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .q       (rt_val)
    );

    // Operand-B mode mux: register, sign/zero-extended immediate, or LUI-style upper immediate.
    always_comb begin
        b_val = rt_val;
        case (alu_src_e'(alu_src))
            ALU_SRC_REG:   b_val = rt_val;
            ALU_SRC_SEXT:  b_val = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
            ALU_SRC_ZEXT:  b_val = {{(WIDTH-IMM_W){1'b0}}, imm};
            ALU_SRC_UPPER: b_val = {imm, {(WIDTH-IMM_W){1'b0}}};
            default:       b_val = rt_val;
        endcase
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Pipeline slot: reset beats flush, flush beats accept; a held slot ignores its inputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: data registers are cleared too, so outputs read zero before the first accept.
            out_valid  <= 1'b0;
            src_a      <= '0;
            src_b      <= '0;
            store_data <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            src_a      <= a_val;
            src_b      <= b_val;
            store_data <= rt_val;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
// Expected forwarding results follow the ALU_OPERAND_FWD_EN build setting.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rd1, rd2;
    logic [4:0]  rs_addr, rt_addr;
    logic [15:0] imm;
    logic [1:0]  alu_src;
    logic        ex_we, wb_we;
    logic [4:0]  ex_addr, wb_addr;
    logic [31:0] ex_data, wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] src_a, src_b, store_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rd1        (rd1),
        .rd2        (rd2),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .imm        (imm),
        .alu_src    (alu_src),
        .ex_we      (ex_we),
        .ex_addr    (ex_addr),
        .ex_data    (ex_data),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .src_a      (src_a),
        .src_b      (src_b),
        .store_data (store_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] src, input logic [15:0] im,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] d1, input logic [31:0] d2);
        in_valid = 1'b1;
        alu_src  = src;
        imm      = im;
        rs_addr  = rs;
        rt_addr  = rt;
        rd1      = d1;
        rd2      = d2;
    endtask

    task automatic set_byp(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                           input logic ww, input logic [4:0] wa, input logic [31:0] wd);
        ex_we = ew; ex_addr = ea; ex_data = ed;
        wb_we = ww; wb_addr = wa; wb_data = wd;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        rd1 = '0; rd2 = '0; rs_addr = '0; rt_addr = '0; imm = '0; alu_src = 2'd0;
        set_byp(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        reset = 1'b0;
        step();

        // Post-reset state, no accept yet.
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_src_a", src_a, 32'h0);
        check("rst_src_b", src_b, 32'h0);
        check("rst_store", store_data, 32'h0);

        // SEXT of a negative immediate.
        set_op(2'd1, 16'h8001, 5'd1, 5'd2, 32'h0000_000A, 32'h0000_000B);
        step();
        check("sext_valid", {31'b0, out_valid}, 32'h1);
        check("sext_src_b", src_b, 32'hFFFF_8001);
        check("sext_src_a", src_a, 32'h0000_000A);
        check("sext_store", store_data, 32'h0000_000B);

        // Back-to-back: ZEXT, UPPER, REG.
        set_op(2'd2, 16'h8001, 5'd1, 5'd2, 32'h0000_000A, 32'h0000_000B);
        step();
        check("zext_src_b", src_b, 32'h0000_8001);
        check("zext_valid", {31'b0, out_valid}, 32'h1);
        set_op(2'd3, 16'h1234, 5'd1, 5'd2, 32'h0000_000A, 32'h0000_000B);
        step();
        check("upper_src_b", src_b, 32'h1234_0000);
        set_op(2'd0, 16'h1234, 5'd1, 5'd2, 32'h0000_000A, 32'hDEAD_BEEF);
        step();
        check("reg_src_b", src_b, 32'hDEAD_BEEF);
        check("reg_store", store_data, 32'hDEAD_BEEF);

        // EX and WB both target r3; EX wins when bypass is built in.
        set_op(2'd0, 16'h0, 5'd3, 5'd7, 32'h0000_0033, 32'h0000_0077);
        set_byp(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        step();
`ifdef ALU_OPERAND_FWD_EN
        check("fwd_ex_prio", src_a, 32'h0000_0011);
`else
        check("nofwd_src_a", src_a, 32'h0000_0033);
`endif
        check("fwd_rt_untouched", src_b, 32'h0000_0077);

        // WB-only match on rt.
        set_op(2'd0, 16'h0, 5'd1, 5'd4, 32'h0000_0010, 32'h0000_0040);
        set_byp(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h44);
        step();
`ifdef ALU_OPERAND_FWD_EN
        check("fwd_wb_src_b", src_b, 32'h0000_0044);
        check("fwd_wb_store", store_data, 32'h0000_0044);
`else
        check("nofwd_src_b", src_b, 32'h0000_0040);
        check("nofwd_store", store_data, 32'h0000_0040);
`endif
        check("fwd_wb_src_a", src_a, 32'h0000_0010);

        // r0 is never forwarded.
        set_op(2'd0, 16'h0, 5'd0, 5'd0, 32'h0, 32'h0);
        set_byp(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'h6);
        step();
        check("r0_src_b", src_b, 32'h0);
        check("r0_src_a", src_a, 32'h0);

        // Load a known op, then stall for 3 cycles while decode inputs change.
        set_byp(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_op(2'd1, 16'h0123, 5'd5, 5'd6, 32'hAAAA_0001, 32'hBBBB_0002);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(2'd2, 16'hF000 + 16'(i), 5'd8, 5'd9, 32'h5000 + 32'(i), 32'h6000 + 32'(i));
            set_byp(1'b1, 5'd8, 32'h9999, 1'b1, 5'd9, 32'h8888);
            step();
            check("stall_src_a", src_a, 32'hAAAA_0001);
            check("stall_src_b", src_b, 32'h0000_0123);
            check("stall_store", store_data, 32'hBBBB_0002);
            check("stall_in_ready", {31'b0, in_ready}, 32'h0);
            check("stall_valid", {31'b0, out_valid}, 32'h1);
        end

        // Release: the pending op loads on the same edge the held one is consumed.
        set_byp(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_op(2'd0, 16'h0, 5'd10, 5'd11, 32'hC0DE_0010, 32'hC0DE_0011);
        out_ready = 1'b1;
        step();
        check("release_valid", {31'b0, out_valid}, 32'h1);
        check("release_src_a", src_a, 32'hC0DE_0010);
        check("release_src_b", src_b, 32'hC0DE_0011);

        // Drain with no new op.
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'b0, out_valid}, 32'h0);
        check("drain_in_ready", {31'b0, in_ready}, 32'h1);

        // Flush with in_valid and a held valid slot.
        set_op(2'd0, 16'h0, 5'd1, 5'd2, 32'h1111_1111, 32'h2222_2222);
        step();
        check("preflush_valid", {31'b0, out_valid}, 32'h1);
        flush = 1'b1;
        out_ready = 1'b0;
        step();
        check("flush_valid", {31'b0, out_valid}, 32'h0);
        flush = 1'b0;

        // Reset in the same cycle as an accept.
        out_ready = 1'b1;
        set_op(2'd3, 16'hABCD, 5'd1, 5'd2, 32'h3333_3333, 32'h4444_4444);
        reset = 1'b1;
        step();
        check("rstacc_valid", {31'b0, out_valid}, 32'h0);
        check("rstacc_src_a", src_a, 32'h0);
        check("rstacc_src_b", src_b, 32'h0);
        check("rstacc_store", store_data, 32'h0);
        reset = 1'b0;
        in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
